// File: rtl/multi_cycle_ctl.sv
// multi_cycle_ctl
//   Multi-cycle control unit. Holds the PC, the instruction register and a
//   five-state sequencer (FETCH/DECODE/EXEC/MEM/WB). It shares a single memory
//   port between instruction fetch and data access. Memory accesses complete
//   on a ready handshake, so any number of wait states is tolerated.
//   Decoded opcodes: R-type, lw, sw, beq, j. Any other opcode is reported
//   for one cycle on o_illegal and otherwise behaves as a NOP.
//
// Parameters
//   PC_W        PC width (word addressed, at most 32)
//   RESET_PC    PC value loaded by reset
//   MEM_WAIT_EN 1: honour i_mem_ready, 0: every access completes at once
//
// Ports
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   i_instr        memory read data, captured into the IR during FETCH
//   i_mem_ready    the current memory access completes this cycle
//   i_zf           ALU zero flag, sampled in EXEC of a beq
//   o_pc, o_ir     current PC and instruction register
//   o_state        FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4
//   o_mem_read/o_mem_write/o_iord       memory port control
//   o_reg_write/o_regdst/o_memtoreg     register file control
//   o_alusrc/o_aluop                    ALU control
//   o_illegal      one-cycle pulse in DECODE for an unknown opcode
module multi_cycle_ctl #(
  parameter int              PC_W        = 9,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter bit              MEM_WAIT_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     i_instr,
  input  logic            i_mem_ready,
  input  logic            i_zf,
  output logic [PC_W-1:0] o_pc,
  output logic [31:0]     o_ir,
  output logic [2:0]      o_state,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_iord,
  output logic            o_reg_write,
  output logic            o_regdst,
  output logic            o_memtoreg,
  output logic            o_alusrc,
  output logic [1:0]      o_aluop,
  output logic            o_illegal
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [5:0] OP_R   = 6'b000000;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J   = 6'b000010;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     ir_q, ir_d;

  logic            mem_ready;
  logic            is_r, is_lw, is_sw, is_beq, is_j;
  logic [PC_W-1:0] br_offset;

  logic            mem_read_c, mem_write_c, iord_c, reg_write_c;
  logic            regdst_c, memtoreg_c, alusrc_c, illegal_c;
  logic [1:0]      aluop_c;

  assign mem_ready = MEM_WAIT_EN ? i_mem_ready : 1'b1;

  assign is_r   = (ir_q[31:26] == OP_R);
  assign is_lw  = (ir_q[31:26] == OP_LW);
  assign is_sw  = (ir_q[31:26] == OP_SW);
  assign is_beq = (ir_q[31:26] == OP_BEQ);
  assign is_j   = (ir_q[31:26] == OP_J);

  // Sign-extend (or truncate) the 16-bit branch immediate to the PC width so
  // the add below wraps modulo 2^PC_W.
  assign br_offset = PC_W'($signed(ir_q[15:0]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    iord_c      = 1'b0;
    reg_write_c = 1'b0;
    regdst_c    = 1'b0;
    memtoreg_c  = 1'b0;
    alusrc_c    = 1'b0;
    aluop_c     = 2'b00;
    illegal_c   = 1'b0;

    unique case (state_q)
      FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_d    = i_instr;
          pc_d    = pc_q + PC_W'(1);
          state_d = DECODE;
        end
      end

      DECODE: begin
        if (is_r || is_lw || is_sw || is_beq) begin
          state_d = EXEC;
        end else if (is_j) begin
          pc_d    = ir_q[PC_W-1:0];
          state_d = FETCH;
        end else begin
          illegal_c = 1'b1;
          state_d   = FETCH;
        end
      end

      EXEC: begin
        if (is_r) begin
          aluop_c = 2'b10;
          state_d = WB;
        end else if (is_lw || is_sw) begin
          alusrc_c = 1'b1;
          state_d  = MEM;
        end else begin
          // beq: the PC already points past the branch, so the offset is
          // relative to the following instruction.
          aluop_c = 2'b01;
          if (i_zf) pc_d = pc_q + br_offset;
          state_d = FETCH;
        end
      end

      MEM: begin
        iord_c      = 1'b1;
        alusrc_c    = 1'b1;
        mem_read_c  = is_lw;
        mem_write_c = is_sw;
        if (mem_ready) state_d = is_lw ? WB : FETCH;
      end

      WB: begin
        reg_write_c = 1'b1;
        if (is_r) begin
          regdst_c = 1'b1;
          aluop_c  = 2'b10;
        end else begin
          memtoreg_c = 1'b1;
        end
        state_d = FETCH;
      end

      default: state_d = FETCH;
    endcase
  end

  // Controls are masked by rst so an in-flight write is dropped the moment
  // reset rises, not at the next clock edge.
  assign o_pc        = pc_q;
  assign o_ir        = ir_q;
  assign o_state     = state_q;
  assign o_mem_read  = mem_read_c  & ~rst;
  assign o_mem_write = mem_write_c & ~rst;
  assign o_iord      = iord_c      & ~rst;
  assign o_reg_write = reg_write_c & ~rst;
  assign o_regdst    = regdst_c    & ~rst;
  assign o_memtoreg  = memtoreg_c  & ~rst;
  assign o_alusrc    = alusrc_c    & ~rst;
  assign o_aluop     = aluop_c     & {2{~rst}};
  assign o_illegal   = illegal_c   & ~rst;

endmodule
